// File: rtl/fb_reader.sv
// fb_reader: credit-limited framebuffer pixel fetcher.
// Converts pixel read requests into SRAM AXI reads and returns colors strictly in request order.
module fb_reader #(
    parameter int PIXEL_BITS      = 12,
    parameter int AXI_ADDR_WIDTH  = 20,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      axi_tvalid,
    output logic                      axi_tready,
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic [AXI_ADDR_WIDTH-1:0] sram_axi_araddr,
    output logic                      sram_axi_arvalid,
    input  logic                      sram_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] sram_axi_rdata,
    input  logic [1:0]                sram_axi_rresp,
    input  logic                      sram_axi_rvalid,
    output logic                      sram_axi_rready,
    output logic                      color_valid,
    input  logic                      color_ready,
    output logic [PIXEL_BITS-1:0]     color,
    output logic                      color_err
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int ENT_W = PIXEL_BITS + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    if (PIXEL_BITS > AXI_DATA_WIDTH) begin : g_bad_pixel_width
        $error("fb_reader: PIXEL_BITS must not exceed AXI_DATA_WIDTH");
    end
    if ((MAX_OUTSTANDING < 2) || ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)) begin : g_bad_depth
        $error("fb_reader: MAX_OUTSTANDING must be a power of 2 and at least 2");
    end

    // Saturation-free up/down step; simultaneous inc and dec cancel out.
    function automatic logic [CNT_W-1:0] step_count(input logic [CNT_W-1:0] cnt,
                                                    input logic inc, input logic dec);
        logic [CNT_W-1:0] nxt;
        case ({inc, dec})
            2'b10:   nxt = cnt + CNT_ONE;
            2'b01:   nxt = cnt - CNT_ONE;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

    logic                      arvalid_r;
    logic [AXI_ADDR_WIDTH-1:0] araddr_r;
    logic [CNT_W-1:0]          credits_r;
    logic [CNT_W-1:0]          outstanding_r;
    logic [CNT_W-1:0]          fifo_cnt_r;
    logic [PTR_W-1:0]          wr_ptr_r;
    logic [PTR_W-1:0]          rd_ptr_r;
    logic [ENT_W-1:0]          fifo_mem_r [MAX_OUTSTANDING];

    logic                      tready_s;
    logic                      rready_s;
    logic                      color_valid_s;
    logic                      req_fire_s;
    logic                      ar_fire_s;
    logic                      r_fire_s;
    logic                      pop_s;
    logic [ENT_W-1:0]          r_entry_s;
    logic [ENT_W-1:0]          head_s;
    logic                      unused_rdata_s;

    // Handshake qualifiers and FIFO head selection.
    always_comb begin
        tready_s      = (credits_r < CNT_MAX) && (!arvalid_r || sram_axi_arready);
        rready_s      = (outstanding_r != CNT_ZERO);
        color_valid_s = (fifo_cnt_r != CNT_ZERO);
        req_fire_s    = axi_tvalid && tready_s;
        ar_fire_s     = arvalid_r && sram_axi_arready;
        r_fire_s      = sram_axi_rvalid && rready_s;
        pop_s         = color_valid_s && color_ready;
        r_entry_s     = {(sram_axi_rresp != 2'b00), sram_axi_rdata[PIXEL_BITS-1:0]};
        head_s        = fifo_mem_r[rd_ptr_r];
    end

    // Only the low PIXEL_BITS of each beat carry color.
    assign unused_rdata_s = ^sram_axi_rdata;

    // AR channel register: load on accept, drop only once the slave takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_r <= 1'b0;
            araddr_r  <= {AXI_ADDR_WIDTH{1'b0}};
        end else if (req_fire_s) begin
            arvalid_r <= 1'b1;
            araddr_r  <= addr;
        end else if (ar_fire_s) begin
            arvalid_r <= 1'b0;
        end
    end

    // Credits cover in-flight reads plus buffered colors, so the FIFO can never overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_r     <= CNT_ZERO;
            outstanding_r <= CNT_ZERO;
        end else begin
            credits_r     <= step_count(credits_r, req_fire_s, pop_s);
            outstanding_r <= step_count(outstanding_r, ar_fire_s, r_fire_s);
        end
    end

    // Response FIFO; power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= CNT_ZERO;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_mem_r[i] <= {ENT_W{1'b0}};
            end
        end else begin
            if (r_fire_s) begin
                fifo_mem_r[wr_ptr_r] <= r_entry_s;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            fifo_cnt_r <= step_count(fifo_cnt_r, r_fire_s, pop_s);
        end
    end

    assign axi_tready       = tready_s;
    assign sram_axi_arvalid = arvalid_r;
    assign sram_axi_araddr  = araddr_r;
    assign sram_axi_rready  = rready_s;
    assign color_valid      = color_valid_s;
    assign color            = head_s[PIXEL_BITS-1:0];
    assign color_err        = head_s[PIXEL_BITS];

endmodule
